// File: rtl/seq_detect_param_pkg.sv
// seq_detect_pkg: shared constants and elaboration-time helpers for the
// parametrised serial sequence detector.
//   pattern_t   - pattern container, sized for the longest legal pattern
//   state_width - bits needed to encode states S_0..S_LEN
//   kmp_next    - next matched-prefix length for one received bit
package seq_detect_pkg;

  localparam int LEN_MIN   = 1;
  localparam int LEN_MAX   = 16;
  localparam int CNT_W_MIN = 2;
  localparam int CNT_W_MAX = 32;

  typedef logic [LEN_MAX-1:0] pattern_t;

  function automatic int state_width(input int len);
    return $clog2(len + 1);
  endfunction

  // Longest pattern prefix that is a suffix of (matched prefix of length k, b).
  // From the full-match state without overlap the history is discarded first.
  // The received string is held oldest-first in str[0..n-1].
  function automatic int kmp_next(input pattern_t pattern, input int len,
                                  input int k, input logic b, input bit overlap);
    int       kk;
    int       n;
    int       res;
    bit       ok;
    bit       found;
    logic [LEN_MAX:0] str;
    kk = (k > len) ? len : k;
    if (kk == len && !overlap) kk = 0;
    str = '0;
    for (int i = 0; i < LEN_MAX; i++) begin
      if (i < kk) str[i] = pattern[len-1-i];
    end
    str[kk] = b;
    n     = kk + 1;
    res   = 0;
    found = 1'b0;
    for (int m = LEN_MAX; m > 0; m--) begin
      if (!found && m <= n && m <= len) begin
        ok = 1'b1;
        for (int j = 0; j < LEN_MAX; j++) begin
          if (j < m && str[n-m+j] != pattern[len-1-j]) ok = 1'b0;
        end
        if (ok) begin
          res   = m;
          found = 1'b1;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/seq_detect_param_if.sv
// seq_detect_param_if: serial stream in, detect status out.
//   en, clr, din           - stream qualifier, sync clear, data bit (master drives)
//   dout, match_cnt, cnt_sat - detect flag, saturating match count, saturation flag
interface seq_detect_param_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic             clr;
  logic             din;
  logic             dout;
  logic [CNT_W-1:0] match_cnt;
  logic             cnt_sat;

  modport master (output en, clr, din, input dout, match_cnt, cnt_sat);
  modport slave  (input en, clr, din, output dout, match_cnt, cnt_sat);
endinterface

// File: rtl/seq_detect_param_sat_counter.sv
// sat_counter: up-counter that sticks at all ones.
//   clk, rst - clock, async active-high reset
//   clr      - synchronous clear, wins over inc
//   inc      - add one unless saturated
//   cnt, sat - count value, high when count is all ones
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         sat
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         full;

  assign full = &cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)              cnt_d = '0;
    else if (inc && !full) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
  assign sat = full;

endmodule

// File: rtl/seq_detect_param.sv
// seq_detect_param: Moore detector for a LEN-bit serial pattern (MSB first)
// with a saturating match counter.
//   clk, rst - clock, async active-high reset
//   bus      - slave side: en/clr/din in, dout/match_cnt/cnt_sat out
//
// state     | meaning
// S_0       | no pattern prefix matched
// S_k       | last k accepted bits equal the first k pattern bits (k maximal)
// S_LEN     | full pattern matched, dout high
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int             LEN     = 3,
  parameter logic [LEN-1:0] PATTERN = 3'b010,
  parameter bit             OVERLAP = 1'b1,
  parameter int             CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  seq_detect_param_if.slave bus
);

  localparam int SW = state_width(LEN);
  localparam int NS = 2 ** SW;

  if (LEN < LEN_MIN || LEN > LEN_MAX) begin : g_bad_len
    $error("seq_detect_param: LEN must be in 1..16");
  end
  if (CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_bad_cnt_w
    $error("seq_detect_param: CNT_W must be in 2..32");
  end

  // Constant next-state table, one row per encodable state; unreachable rows
  // point back to S_0.
  logic [SW-1:0] nxt_tbl [NS][2];

  for (genvar k = 0; k < NS; k++) begin : g_row
    for (genvar b = 0; b < 2; b++) begin : g_col
      localparam int NXT = (k <= LEN) ?
        kmp_next(LEN_MAX'(PATTERN), LEN, k, 1'(b), OVERLAP) : 0;
      assign nxt_tbl[k][b] = SW'(NXT);
    end
  end

  logic [SW-1:0] state_q;
  logic [SW-1:0] state_d;
  logic          hit;
  logic          dout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= '0;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    hit     = 1'b0;
    if (bus.clr) begin
      state_d = '0;
    end else if (bus.en) begin
      state_d = nxt_tbl[state_q][bus.din];
      hit     = (state_d == SW'(LEN));
    end
  end

  always_comb begin
    dout = (state_q == SW'(LEN));
  end

  assign bus.dout = dout;

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (bus.clr),
    .inc (hit),
    .cnt (bus.match_cnt),
    .sat (bus.cnt_sat)
  );

endmodule

// File: tb/tb_seq_detect_param.sv
module tb_seq_detect_param;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  seq_detect_param_if #(.CNT_W(8)) if0 ();
  seq_detect_param_if #(.CNT_W(8)) if1 ();
  seq_detect_param_if #(.CNT_W(8)) if2 ();
  seq_detect_param_if #(.CNT_W(2)) if3 ();

  seq_detect_param #(.LEN(3), .PATTERN(3'b010), .OVERLAP(1'b1), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .bus(if0));
  seq_detect_param #(.LEN(3), .PATTERN(3'b010), .OVERLAP(1'b0), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .bus(if1));
  seq_detect_param #(.LEN(2), .PATTERN(2'b11), .OVERLAP(1'b1), .CNT_W(8)) dut2 (
    .clk(clk), .rst(rst), .bus(if2));
  seq_detect_param #(.LEN(3), .PATTERN(3'b010), .OVERLAP(1'b1), .CNT_W(2)) dut3 (
    .clk(clk), .rst(rst), .bus(if3));

  typedef struct {
    int          id;
    logic        d;
    logic [31:0] c;
    logic        s;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  event sample_ev;

  task automatic get_act(input int id, output logic d, output logic [31:0] c,
                         output logic s);
    case (id)
      0:       begin d = if0.dout; c = 32'(if0.match_cnt); s = if0.cnt_sat; end
      1:       begin d = if1.dout; c = 32'(if1.match_cnt); s = if1.cnt_sat; end
      2:       begin d = if2.dout; c = 32'(if2.match_cnt); s = if2.cnt_sat; end
      default: begin d = if3.dout; c = 32'(if3.match_cnt); s = if3.cnt_sat; end
    endcase
  endtask

  // Outputs are sampled 1 time unit after each rising edge, or on demand.
  always @(posedge clk) begin
    #1;
    ->sample_ev;
  end

  initial begin
    exp_t        e;
    logic        ad;
    logic [31:0] ac;
    logic        as;
    forever begin
      @(sample_ev);
      while (q.size() > 0) begin
        e = q.pop_front();
        get_act(e.id, ad, ac, as);
        n_cmp++;
        if (ad !== e.d || ac !== e.c || as !== e.s) begin
          n_bad++;
          $display("FAIL %s dut%0d: got dout=%0b cnt=%0d sat=%0b, want dout=%0b cnt=%0d sat=%0b",
                   e.name, e.id, ad, ac, as, e.d, e.c, e.s);
        end
      end
    end
  end

  task automatic drive(input int id, input logic en, input logic clr, input logic din);
    if0.en = 1'b0; if0.clr = 1'b0; if0.din = 1'b0;
    if1.en = 1'b0; if1.clr = 1'b0; if1.din = 1'b0;
    if2.en = 1'b0; if2.clr = 1'b0; if2.din = 1'b0;
    if3.en = 1'b0; if3.clr = 1'b0; if3.din = 1'b0;
    case (id)
      0: begin if0.en = en; if0.clr = clr; if0.din = din; end
      1: begin if1.en = en; if1.clr = clr; if1.din = din; end
      2: begin if2.en = en; if2.clr = clr; if2.din = din; end
      3: begin if3.en = en; if3.clr = clr; if3.din = din; end
      default: ;
    endcase
  endtask

  task automatic push(input int id, input logic d, input int c, input logic s,
                      input string name);
    exp_t e;
    e.id = id; e.d = d; e.c = 32'(c); e.s = s; e.name = name;
    q.push_back(e);
  endtask

  // One clock of stimulus; the expectation is checked just after the edge.
  task automatic step(input int id, input logic en, input logic clr, input logic din,
                      input logic d, input int c, input logic s, input string name);
    @(negedge clk);
    drive(id, en, clr, din);
    push(id, d, c, s, name);
    @(posedge clk);
  endtask

  initial begin
    int pc;
    int nc;
    drive(-1, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) push(i, 1'b0, 0, 1'b0, "reset");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 010 repeated ten times: one pulse per repetition
    for (int r = 0; r < 10; r++) begin
      step(0, 1, 0, 0, 0, r,     0, "rep_b0");
      step(0, 1, 0, 1, 0, r,     0, "rep_b1");
      step(0, 1, 0, 0, 1, r + 1, 0, "rep_b2");
    end

    // clr together with a bit that would complete a match
    step(0, 1, 0, 0, 0, 10, 0, "pre_clr_0");
    step(0, 1, 0, 1, 0, 10, 0, "pre_clr_1");
    step(0, 1, 1, 0, 0, 0,  0, "clr_wins");

    // 01010 with overlap: matches on bits 3 and 5
    step(0, 1, 0, 0, 0, 0, 0, "ovl_b1");
    step(0, 1, 0, 1, 0, 0, 0, "ovl_b2");
    step(0, 1, 0, 0, 1, 1, 0, "ovl_b3");
    step(0, 1, 0, 1, 0, 1, 0, "ovl_b4");
    step(0, 1, 0, 0, 1, 2, 0, "ovl_b5");

    // 01010 without overlap: only bit 3 matches
    step(1, 1, 0, 0, 0, 0, 0, "novl_b1");
    step(1, 1, 0, 1, 0, 0, 0, "novl_b2");
    step(1, 1, 0, 0, 1, 1, 0, "novl_b3");
    step(1, 1, 0, 1, 0, 1, 0, "novl_b4");
    step(1, 1, 0, 0, 0, 1, 0, "novl_b5");

    // pattern 11 on 1111: detect held three cycles
    step(2, 1, 0, 1, 0, 0, 0, "p11_b1");
    step(2, 1, 0, 1, 1, 1, 0, "p11_b2");
    step(2, 1, 0, 1, 1, 2, 0, "p11_b3");
    step(2, 1, 0, 1, 1, 3, 0, "p11_b4");
    step(2, 1, 0, 0, 0, 3, 0, "p11_b5");

    // en low freezes everything while din toggles
    step(0, 1, 1, 0, 0, 0, 0, "hold_clr");
    step(0, 1, 0, 0, 0, 0, 0, "hold_b0");
    step(0, 1, 0, 1, 0, 0, 0, "hold_b1");
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1'(i), 0, 0, 0, "hold_en0");
    step(0, 1, 0, 0, 1, 1, 0, "hold_match");

    // 2-bit counter saturates at 3
    for (int m = 1; m <= 5; m++) begin
      pc = (m - 1 > 3) ? 3 : m - 1;
      nc = (m > 3) ? 3 : m;
      step(3, 1, 0, 0, 0, pc, 1'(pc == 3), "sat_b0");
      step(3, 1, 0, 1, 0, pc, 1'(pc == 3), "sat_b1");
      step(3, 1, 0, 0, 1, nc, 1'(nc == 3), "sat_b2");
    end
    step(3, 1, 1, 0, 0, 0, 0, "sat_clr");

    // async reset mid-pattern (dut0 sits in S_2 with count 1)
    step(0, 1, 0, 1, 0, 1, 0, "pre_rst_1");
    #3;
    rst = 1'b1;
    push(0, 1'b0, 0, 1'b0, "rst_async");
    #1;
    ->sample_ev;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step(0, 1, 0, 0, 0, 0, 0, "post_rst_0");
    step(0, 1, 0, 1, 0, 0, 0, "post_rst_1");
    step(0, 1, 0, 0, 1, 1, 0, "post_rst_2");

    @(negedge clk);
    drive(-1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
